// File: rtl/msiq_ctl_pkg.sv
// msiq_ctl_pkg: shared constants and types for the SMC address CAM write-side
// controller.
//   MSIQ_ADDR_W      line-address width used by the CAM wrt_addr port
//   MSIQ_WAYS        number of CAM slots
//   msiq_ctl_state_t controller state encoding
package msiq_ctl_pkg;

  localparam int MSIQ_ADDR_W = 37;
  localparam int MSIQ_WAYS   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    CLEAR  = 2'd3
  } msiq_ctl_state_t;

endpackage

// File: rtl/msiq_ctl_if.sv
// msiq_ctl_if: invalidate-request and CAM write bus of msiq_ctl.
//   inv_addr/inv_vld/inv_rdy  inbound invalidate handshake
//   wrt_addr/wrt_en           CAM write port
//   wrt_can                   CAM has a free slot (registered in the CAM)
//   all_clear                 CAM free-all strobe
// master: the environment (snoop path + CAM); slave: msiq_ctl.
interface msiq_ctl_if #(
  parameter int ADDR_W = 37
);
  logic [ADDR_W-1:0] inv_addr;
  logic              inv_vld;
  logic              inv_rdy;
  logic [ADDR_W-1:0] wrt_addr;
  logic              wrt_en;
  logic              wrt_can;
  logic              all_clear;

  modport master (
    output inv_addr, inv_vld, wrt_can,
    input  inv_rdy, wrt_addr, wrt_en, all_clear
  );

  modport slave (
    input  inv_addr, inv_vld, wrt_can,
    output inv_rdy, wrt_addr, wrt_en, all_clear
  );
endinterface

// File: rtl/msiq_ctl_fifo.sv
// msiq_ctl_fifo: pointer-based inbound address FIFO with registered count.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i, din_i    write request and data (ignored when full)
//   pop_i            read request (ignored when empty)
//   head_o           oldest entry, combinational
//   tail_o           newest entry (only with MSIQ_CTL_DEDUP_EN defined)
//   full_o, empty_o  status from the registered count
//   cnt_o            occupancy
// Macro: MSIQ_CTL_DEDUP_EN adds the tail_o port.
module msiq_ctl_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [ADDR_W-1:0]        din_i,
  input  logic                     pop_i,
  output logic [ADDR_W-1:0]        head_o,
`ifdef MSIQ_CTL_DEDUP_EN
  output logic [ADDR_W-1:0]        tail_o,
`endif
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
`ifdef MSIQ_CTL_DEDUP_EN
  assign tail_o  = mem_q[wr_ptr_q - PW'(1)];
`endif
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/msiq_ctl.sv
// msiq_ctl: write-side controller for the 8-entry SMC address CAM.
// Queues invalidate addresses, writes them into the CAM while it has room,
// and frees the CAM with all_clear once the pipeline fences, forcing a
// pipeline flush first if the CAM is full with work pending or if the
// hazard window stays open for TIMEOUT cycles.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus            msiq_ctl_if slave (invalidate handshake + CAM write port)
//   fence_done_i   all older ops retired or flushed
//   flush_ack_i    single-cycle flush completion
//   flush_req_o    pipeline flush request, held until flush_ack_i
//   busy_o         not IDLE or FIFO not empty
//   fifo_cnt_o     FIFO occupancy
// Macro: MSIQ_CTL_DEDUP_EN drops an incoming address equal to the FIFO tail
// or, while ACTIVE, to the last address written.
//
// state  | meaning
// IDLE   | CAM empty of live hazards; first write moves to ACTIVE
// ACTIVE | CAM holds entries; waiting for fence, CAM-full or timeout
// FLUSH  | flush_req held, waiting for flush_ack
// CLEAR  | one-cycle all_clear to the CAM
module msiq_ctl
  import msiq_ctl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = MSIQ_ADDR_W,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  msiq_ctl_if.slave              bus,
  input  logic                   fence_done_i,
  input  logic                   flush_ack_i,
  output logic                   flush_req_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_cnt_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = 8;

  logic [ADDR_W-1:0] head;
  logic              full, empty, accept, push, pop;
  logic [CW-1:0]     cnt;
  msiq_ctl_state_t   state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              all_clear_q, flush_req_q;

  assign accept = bus.inv_vld && !full;
  assign pop    = !empty && bus.wrt_can && (state_q == IDLE || state_q == ACTIVE);

`ifdef MSIQ_CTL_DEDUP_EN
  logic [ADDR_W-1:0] tail, last_wr_q;
  logic              dup;

  always_ff @(posedge clk) begin
    if (rst)      last_wr_q <= '0;
    else if (pop) last_wr_q <= head;
  end

  // A duplicate is still handshaken, just not stored.
  assign dup  = (!empty && bus.inv_addr == tail) ||
                (state_q == ACTIVE && bus.inv_addr == last_wr_q);
  assign push = accept && !dup;
`else
  assign push = accept;
`endif

  msiq_ctl_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus.inv_addr),
    .pop_i   (pop),
    .head_o  (head),
`ifdef MSIQ_CTL_DEDUP_EN
    .tail_o  (tail),
`endif
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  // timer_q counts cycles elapsed since the last write, the write cycle
  // itself being count 0; the timeout fires TIMEOUT cycles after a write.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pop) begin
          state_d = ACTIVE;
          timer_d = TW'(1);
        end
      end
      ACTIVE: begin
        if (pop) begin
          timer_d = TW'(1);
        end else if (fence_done_i) begin
          state_d = CLEAR;
          timer_d = '0;
        end else if ((!bus.wrt_can && !empty) || timer_q == TW'(TIMEOUT - 1)) begin
          state_d = FLUSH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FLUSH: begin
        if (flush_ack_i) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      all_clear_q <= 1'b0;
      flush_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      all_clear_q <= (state_d == CLEAR);
      flush_req_q <= (state_d == FLUSH);
    end
  end

  assign bus.inv_rdy   = !full;
  assign bus.wrt_en    = pop;
  assign bus.wrt_addr  = head;
  assign bus.all_clear = all_clear_q;
  assign flush_req_o   = flush_req_q;
  assign busy_o        = (state_q != IDLE) || !empty;
  assign fifo_cnt_o    = cnt;

endmodule

// File: tb/tb_msiq_ctl.sv
// tb_msiq_ctl: self-checking bench for msiq_ctl (DEPTH=4, TIMEOUT=16).
// A CAM model supplies wrt_can; directed scenarios plus a randomized run
// checked against a queue-based reference.
module tb_msiq_ctl;
  import msiq_ctl_pkg::*;

  localparam int AW = 37;

  logic       clk;
  logic       rst;
  logic       fence_done;
  logic       flush_ack;
  logic       flush_req;
  logic       busy;
  logic [2:0] fifo_cnt;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int cam_free = MSIQ_WAYS;
  bit cam_block = 0;

  msiq_ctl_if #(.ADDR_W(AW)) bus ();

  msiq_ctl #(.DEPTH(4), .ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .fence_done_i (fence_done),
    .flush_ack_i  (flush_ack),
    .flush_req_o  (flush_req),
    .busy_o       (busy),
    .fifo_cnt_o   (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Middle of the current cycle: inputs settled, outputs stable.
  task automatic mid();
    @(negedge clk);
  endtask

  // End the current cycle and update the CAM model from what it saw.
  task automatic fin();
    logic we, ac;
    we = bus.wrt_en;
    ac = bus.all_clear;
    @(posedge clk);
    #1;
    if (ac) cam_free = MSIQ_WAYS;
    else if (we && cam_free > 0) cam_free--;
    bus.wrt_can = (cam_free != 0) && !cam_block;
    cyc_n++;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.inv_vld = 1'b0;
    bus.inv_addr = '0;
    fence_done = 1'b0;
    flush_ack = 1'b0;
    cam_block = 0;
    cam_free = MSIQ_WAYS;
    bus.wrt_can = 1'b1;
    mid(); fin();
    mid(); fin();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    mid();
    tests++; if (bus.inv_rdy !== 1'b1) begin fails++; $display("FAIL reset_inv_rdy got %0b want 1", bus.inv_rdy); end
    tests++; if (bus.wrt_en !== 1'b0) begin fails++; $display("FAIL reset_wrt_en got %0b want 0", bus.wrt_en); end
    tests++; if (bus.all_clear !== 1'b0) begin fails++; $display("FAIL reset_all_clear got %0b want 0", bus.all_clear); end
    tests++; if (flush_req !== 1'b0) begin fails++; $display("FAIL reset_flush_req got %0b want 0", flush_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (fifo_cnt !== 3'd0) begin fails++; $display("FAIL reset_fifo_cnt got %0d want 0", fifo_cnt); end
    fin();
  endtask

  task automatic test_single_fence();
    logic [AW-1:0] a;
    reset_dut();
    a = 37'h1_0000_0040;
    bus.inv_addr = a; bus.inv_vld = 1'b1;
    mid();
    tests++; if (bus.wrt_en !== 1'b0) begin fails++; $display("FAIL fence_no_same_cycle_wr got %0b want 0", bus.wrt_en); end
    fin();
    bus.inv_vld = 1'b0;
    mid();
    tests++; if (bus.wrt_en !== 1'b1) begin fails++; $display("FAIL fence_wrt_en got %0b want 1", bus.wrt_en); end
    tests++; if (bus.wrt_addr !== a) begin fails++; $display("FAIL fence_wrt_addr got %h want %h", bus.wrt_addr, a); end
    fin();
    mid(); fin();
    mid(); fin();
    fence_done = 1'b1;
    mid();
    tests++; if (bus.all_clear !== 1'b0) begin fails++; $display("FAIL fence_early_clear got %0b want 0", bus.all_clear); end
    fin();
    fence_done = 1'b0;
    mid();
    tests++; if (bus.all_clear !== 1'b1) begin fails++; $display("FAIL fence_all_clear got %0b want 1", bus.all_clear); end
    fin();
    mid();
    tests++; if (bus.all_clear !== 1'b0) begin fails++; $display("FAIL fence_clear_width got %0b want 0", bus.all_clear); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL fence_busy got %0b want 0", busy); end
    fin();
  endtask

  task automatic test_fill_cam();
    logic [AW-1:0] a [10];
    logic [AW-1:0] got_a [$];
    int got_c [$];
    int sent, fr, ac, pre, bad_order, c8, c9;
    bit held_bad;
    reset_dut();
    for (int k = 0; k < 10; k++) a[k] = {5'h3, 16'(k * 7 + 1), 16'(k)};
    sent = 0; fr = -1; ac = -1; held_bad = 0;
    for (int i = 0; i < 40; i++) begin
      bus.inv_vld = (sent < 10);
      bus.inv_addr = (sent < 10) ? a[sent] : '0;
      flush_ack = (fr >= 0 && cyc_n == fr + 5);
      mid();
      if (bus.wrt_en) begin got_a.push_back(bus.wrt_addr); got_c.push_back(cyc_n); end
      if (flush_req && fr < 0) fr = cyc_n;
      if (bus.all_clear && ac < 0) ac = cyc_n;
      if (fr >= 0 && cyc_n <= fr + 5 && !flush_req) held_bad = 1;
      if (bus.inv_vld && bus.inv_rdy) sent++;
      fin();
    end
    bus.inv_vld = 1'b0; flush_ack = 1'b0;
    pre = 0; bad_order = 0;
    foreach (got_a[k]) begin
      if (k < 10 && got_a[k] !== a[k]) bad_order++;
      if (fr >= 0 && got_c[k] < fr) pre++;
    end
    c8 = (got_c.size() == 10) ? got_c[8] : -1;
    c9 = (got_c.size() == 10) ? got_c[9] : -1;
    tests++; if (got_a.size() != 10) begin fails++; $display("FAIL fill_write_count got %0d want 10", got_a.size()); end
    tests++; if (bad_order != 0) begin fails++; $display("FAIL fill_order got %0d bad want 0", bad_order); end
    tests++; if (fr < 0) begin fails++; $display("FAIL fill_flush_req got none want asserted"); end
    tests++; if (pre != 8) begin fails++; $display("FAIL fill_writes_before_flush got %0d want 8", pre); end
    tests++; if (held_bad) begin fails++; $display("FAIL fill_flush_held got dropped want held"); end
    tests++; if (ac != fr + 6) begin fails++; $display("FAIL fill_clear_cycle got %0d want %0d", ac, fr + 6); end
    tests++; if (c8 != ac + 1 || c9 != ac + 2) begin fails++; $display("FAIL fill_tail_writes got %0d,%0d want %0d,%0d", c8, c9, ac + 1, ac + 2); end
  endtask

  task automatic test_timeout();
    int wc, fc, ac;
    reset_dut();
    wc = -1; fc = -1; ac = -1;
    bus.inv_addr = 37'h0_1234_5680;
    for (int i = 0; i < 40; i++) begin
      bus.inv_vld = (i == 0);
      flush_ack = (fc >= 0 && cyc_n == fc + 1);
      mid();
      if (bus.wrt_en && wc < 0) wc = cyc_n;
      if (flush_req && fc < 0) fc = cyc_n;
      if (bus.all_clear && ac < 0) ac = cyc_n;
      fin();
    end
    flush_ack = 1'b0;
    mid();
    tests++; if (wc < 0 || fc != wc + 16) begin fails++; $display("FAIL timeout_flush_cycle got %0d want %0d", fc - wc, 16); end
    tests++; if (ac != fc + 2) begin fails++; $display("FAIL timeout_clear_cycle got %0d want %0d", ac, fc + 2); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got %0b want 0", busy); end
    fin();
  endtask

  task automatic test_collision();
    reset_dut();
    bus.inv_addr = 37'h0_0000_0abc; bus.inv_vld = 1'b1;
    mid(); fin();
    bus.inv_vld = 1'b0; fence_done = 1'b1;
    mid();
    tests++; if (bus.wrt_en !== 1'b1) begin fails++; $display("FAIL coll_wrt_en got %0b want 1", bus.wrt_en); end
    fin();
    mid();
    tests++; if (bus.all_clear !== 1'b0 || flush_req !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL coll_stays_active got clr=%0b fr=%0b busy=%0b want 0 0 1", bus.all_clear, flush_req, busy);
    end
    fin();
    fence_done = 1'b0;
    mid();
    tests++; if (bus.all_clear !== 1'b1) begin fails++; $display("FAIL coll_clear got %0b want 1", bus.all_clear); end
    fin();
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] b [6];
    reset_dut();
    for (int k = 0; k < 6; k++) b[k] = {21'h1_5a5a, 16'(k + 100)};
    cam_block = 1; bus.wrt_can = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.inv_addr = b[k]; bus.inv_vld = 1'b1;
      mid();
      tests++; if (bus.inv_rdy !== (k < 4)) begin fails++; $display("FAIL full_inv_rdy_%0d got %0b want %0b", k, bus.inv_rdy, k < 4); end
      fin();
    end
    bus.inv_vld = 1'b0;
    mid();
    tests++; if (fifo_cnt !== 3'd4 || bus.wrt_en !== 1'b0) begin fails++; $display("FAIL full_count got %0d we=%0b want 4 0", fifo_cnt, bus.wrt_en); end
    fin();
    cam_block = 0; bus.wrt_can = 1'b1;
    mid();
    tests++; if (bus.wrt_en !== 1'b1 || bus.wrt_addr !== b[0]) begin fails++; $display("FAIL full_drain0 got %h want %h", bus.wrt_addr, b[0]); end
    fin();
    mid(); fin();
    bus.inv_addr = b[5]; bus.inv_vld = 1'b1;
    mid();
    tests++; if (fifo_cnt !== 3'd2 || bus.wrt_addr !== b[2] || bus.inv_rdy !== 1'b1) begin
      fails++; $display("FAIL full_pushpop_pre got cnt=%0d addr=%h want 2 %h", fifo_cnt, bus.wrt_addr, b[2]);
    end
    fin();
    bus.inv_vld = 1'b0;
    mid();
    tests++; if (fifo_cnt !== 3'd2 || bus.wrt_addr !== b[3]) begin fails++; $display("FAIL full_pushpop_cnt got cnt=%0d addr=%h want 2 %h", fifo_cnt, bus.wrt_addr, b[3]); end
    fin();
    mid();
    tests++; if (bus.wrt_addr !== b[5]) begin fails++; $display("FAIL full_new_entry got %h want %h", bus.wrt_addr, b[5]); end
    fin();
  endtask

  task automatic test_dedup();
    int nwr, want;
    reset_dut();
    nwr = 0;
    bus.inv_addr = 37'h40;
    for (int i = 0; i < 8; i++) begin
      bus.inv_vld = (i < 2);
      mid();
      if (bus.wrt_en) nwr++;
      fin();
    end
    bus.inv_vld = 1'b0;
`ifdef MSIQ_CTL_DEDUP_EN
    want = 1;
`else
    want = 2;
`endif
    tests++; if (nwr != want) begin fails++; $display("FAIL dedup_writes got %0d want %0d", nwr, want); end
  endtask

  task automatic test_random();
    logic [AW-1:0] q [$];
    logic [AW-1:0] nxt;
    logic [31:0] r;
    int seq, wait_n, errs;
    bit pend, exp_we, prev_clr, done;
    reset_dut();
    seq = 0; pend = 0; wait_n = 0; errs = 0; prev_clr = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom();
      nxt = {r[20:0], 16'(seq)};
      bus.inv_vld = (i < 1300) && ($urandom_range(0, 2) != 0);
      bus.inv_addr = nxt;
      fence_done = ($urandom_range(0, 9) == 0);
      flush_ack = 1'b0;
      if (pend) begin
        if (wait_n == 0) begin flush_ack = 1'b1; pend = 0; end
        else wait_n--;
      end
      mid();
      exp_we = (q.size() > 0) && bus.wrt_can && !bus.all_clear && !flush_req;
      tests++; if (bus.wrt_en !== exp_we) begin fails++; $display("FAIL rnd_wrt_en cyc %0d got %0b want %0b", cyc_n, bus.wrt_en, exp_we); end
      tests++; if (fifo_cnt !== 3'(q.size())) begin fails++; $display("FAIL rnd_fifo_cnt cyc %0d got %0d want %0d", cyc_n, fifo_cnt, q.size()); end
      tests++; if (bus.inv_rdy !== (q.size() < 4)) begin fails++; $display("FAIL rnd_inv_rdy cyc %0d got %0b want %0b", cyc_n, bus.inv_rdy, q.size() < 4); end
      if (bus.wrt_en && q.size() > 0) begin
        tests++; if (bus.wrt_addr !== q[0]) begin fails++; $display("FAIL rnd_wrt_addr cyc %0d got %h want %h", cyc_n, bus.wrt_addr, q[0]); end
        void'(q.pop_front());
      end
      if (prev_clr && bus.all_clear) errs++;
      prev_clr = bus.all_clear;
      if (bus.inv_vld && bus.inv_rdy) begin q.push_back(nxt); seq++; end
      if (flush_req && !pend && !flush_ack) begin pend = 1; wait_n = $urandom_range(0, 3); end
      fin();
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL rnd_clear_pulse got %0d long pulses want 0", errs); end
    bus.inv_vld = 1'b0;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      fence_done = ($urandom_range(0, 3) == 0);
      flush_ack = 1'b0;
      if (pend) begin
        if (wait_n == 0) begin flush_ack = 1'b1; pend = 0; end
        else wait_n--;
      end
      mid();
      if (bus.wrt_en && q.size() > 0) void'(q.pop_front());
      if (flush_req && !pend && !flush_ack) begin pend = 1; wait_n = $urandom_range(0, 3); end
      done = !busy;
      fin();
    end
    fence_done = 1'b0; flush_ack = 1'b0;
    tests++; if (!done || q.size() != 0) begin fails++; $display("FAIL rnd_drain got busy_end=%0b left=%0d want idle 0", !done, q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.inv_vld = 1'b0;
    bus.inv_addr = '0;
    bus.wrt_can = 1'b1;
    fence_done = 1'b0;
    flush_ack = 1'b0;
    test_reset();
    test_single_fence();
    test_fill_cam();
    test_timeout();
    test_collision();
    test_fifo_full();
    test_dedup();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
